// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART TX line among NREQ byte producers. Pending requests are
// served round-robin; each granted byte is sent as an 8N1 frame (start bit
// low, 8 data bits LSB first, stop bit high), with the bit period derived
// from the system clock. The line idles high.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   req      in   [NREQ]    level request per requester
//   data     in   [8*NREQ]  byte of requester i on data[8i+7:8i]
//   grant    out  [NREQ]    one-hot, one-cycle pulse: that requester's byte latched
//   owner    out  [OW]      index of the requester owning the current frame
//   busy     out            frame in progress
//   baud     out            one-cycle pulse on the last clock of each bit period
//   tx       out            serial line, idle high
//
// Timing: the grant pulse appears while the line is still idle (busy low);
// the start bit begins the following cycle. Arbitration also happens on the
// last clock of a stop bit, so back-to-back frames are separated by exactly
// one idle-high clock (the cycle carrying the next grant).
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int CLKS_PER_BAUD = 434,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   grant,
  output logic [OW-1:0]     owner,
  output logic              busy,
  output logic              baud,
  output logic              tx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Registered state and outputs
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic [OW-1:0]     r_last;
  logic [OW-1:0]     r_owner;
  logic [NREQ-1:0]   r_grant;
  logic              r_busy;
  logic              r_baud;
  logic              r_tx;

  // Next-state values
  state_t            w_state_next;
  logic [CW-1:0]     w_cnt_next;
  logic [2:0]        w_bit_next;
  logic [7:0]        w_shift_next;
  logic [OW-1:0]     w_last_next;
  logic [OW-1:0]     w_owner_next;
  logic [NREQ-1:0]   w_grant_next;
  logic              w_busy_next;
  logic              w_baud_next;
  logic              w_tx_next;

  logic              w_bit_end;
  logic              w_arb;
  logic              w_any_req;
  logic [OW-1:0]     w_sel;
  logic [7:0]        w_sel_byte;
  logic [7:0]        w_bytes [NREQ];

  // Split the flat data bus into per-requester bytes
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
      assign w_bytes[gi] = data[8*gi +: 8];
    end
  endgenerate

  assign w_any_req  = |req;
  assign w_sel_byte = w_bytes[w_sel];
  assign w_bit_end  = (r_cnt == CW'(CLKS_PER_BAUD - 1));

  // Round-robin pick: scan offsets NREQ down to 1 from the last grant, so the
  // smallest offset with a pending request is the one that sticks.
  always_comb begin
    w_sel = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(r_last) + k) % NREQ]) begin
        w_sel = OW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  // Next-state / next-output logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_last_next  = r_last;
    w_owner_next = r_owner;
    w_grant_next = '0;
    w_arb        = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        // A grant issued last cycle means the byte is already latched
        if (r_grant != '0) begin
          w_state_next = START;
        end else begin
          w_arb = 1'b1;
        end
      end
      START: begin
        w_cnt_next = w_bit_end ? '0 : r_cnt + CW'(1);
        if (w_bit_end) begin
          w_state_next = DATA;
          w_bit_next   = 3'd0;
        end
      end
      DATA: begin
        w_cnt_next = w_bit_end ? '0 : r_cnt + CW'(1);
        if (w_bit_end) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_next = STOP;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
      STOP: begin
        w_cnt_next = w_bit_end ? '0 : r_cnt + CW'(1);
        if (w_bit_end) begin
          w_state_next = IDLE;
          // Arbitrate on the final stop clock so the next grant lands on
          // the first idle cycle.
          w_arb        = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase

    if (w_arb && w_any_req) begin
      w_grant_next = NREQ'(1) << w_sel;
      w_shift_next = w_sel_byte;
      w_owner_next = w_sel;
      w_last_next  = w_sel;
    end

    w_busy_next = (w_state_next != IDLE);
    w_baud_next = w_busy_next && (w_cnt_next == CW'(CLKS_PER_BAUD - 1));
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_last  <= OW'(NREQ - 1);
      r_owner <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_baud  <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_last  <= w_last_next;
      r_owner <= w_owner_next;
      r_grant <= w_grant_next;
      r_busy  <= w_busy_next;
      r_baud  <= w_baud_next;
      r_tx    <= w_tx_next;
    end
  end

  assign grant = r_grant;
  assign owner = r_owner;
  assign busy  = r_busy;
  assign baud  = r_baud;
  assign tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic        baud;
  logic        tx;

  int n_checks;
  int n_pass;

  uart_tx_arbiter #(
    .NREQ(4),
    .CLKS_PER_BAUD(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .data(data),
    .grant(grant),
    .owner(owner),
    .busy(busy),
    .baud(baud),
    .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Waits (bounded) for a grant pulse, checks it, then steps into the first
  // START cycle and checks the pulse has ended and the start bit is on the line.
  task automatic wait_grant(input logic [3:0] g, input logic [1:0] o,
                            input string tag, output int n);
    n = 0;
    while (grant == 4'd0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_owner"}, 32'(owner), 32'(o));
    chk({tag, "_gidle"}, {30'd0, busy, tx}, 32'b01);
    tick();
    chk({tag, "_pulse"}, {27'd0, grant, tx}, 32'd0);
  endtask

  // Called on the first START cycle; checks 40 line cycles and ends on the
  // first cycle after the frame.
  task automatic frame(input logic [7:0] b, input string tag);
    logic [9:0] bits;
    logic [7:0] dec;
    int nb;
    bits = {1'b1, b, 1'b0};
    dec  = 8'd0;
    nb   = 0;
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("%s_line%0d", tag, i), {29'd0, busy, baud, tx},
          {29'd0, 1'b1, (i % 4 == 3), bits[i / 4]});
      if (i / 4 >= 1 && i / 4 <= 8 && i % 4 == 2) dec[i / 4 - 1] = tx;
      if (baud) nb++;
      tick();
    end
    chk({tag, "_byte"}, 32'(dec), 32'(b));
    chk({tag, "_nbaud"}, 32'(nb), 32'd10);
    chk({tag, "_end"}, {30'd0, busy, tx}, 32'b01);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    req      = 4'd0;
    data     = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_out", {23'd0, tx, busy, baud, grant, owner}, {23'd0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0});
    reset_n = 1'b1;

    // Idle line with no requests
    for (int i = 0; i < 50; i++) begin
      tick();
      chk($sformatf("idle%0d", i), {25'd0, tx, busy, baud, grant}, {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    end

    // Single request from requester 2, byte A5
    req  = 4'b0100;
    data = 32'h00A5_0000;
    wait_grant(4'b0100, 2'd2, "single", n);
    req = 4'd0;
    frame(8'hA5, "single");
    tick();
    chk("single_quiet", {26'd0, grant, busy, tx}, 32'b01);

    // Requester 3 byte 3C, data changed to FF right after the grant
    req  = 4'b1000;
    data = 32'h3C00_0000;
    wait_grant(4'b1000, 2'd3, "chg", n);
    req  = 4'd0;
    data = 32'hFF00_0000;
    frame(8'h3C, "chg");

    // All four held: rotation 0,1,2,3,0 back-to-back
    req  = 4'b1111;
    data = 32'h3322_1100;
    for (int k = 0; k < 5; k++) begin
      wait_grant(4'b0001 << (k % 4), 2'(k % 4), $sformatf("rr%0d", k), n);
      if (k > 0) chk($sformatf("rr%0d_gap", k), 32'(n), 32'd0);
      if (k == 4) req = 4'd0;
      frame(8'h11 * 8'(k % 4), $sformatf("rr%0d", k));
    end

    // Fairness after wrap: grant 3, then req 1001 -> 0 then 3
    req  = 4'b1000;
    data = 32'hC300_005A;
    wait_grant(4'b1000, 2'd3, "wrap_a", n);
    req = 4'd0;
    frame(8'hC3, "wrap_a");
    req = 4'b1001;
    wait_grant(4'b0001, 2'd0, "wrap_b", n);
    req = 4'b1000;
    frame(8'h5A, "wrap_b");
    wait_grant(4'b1000, 2'd3, "wrap_c", n);
    chk("wrap_c_gap", 32'(n), 32'd0);
    req = 4'd0;
    frame(8'hC3, "wrap_c");

    // Reset during DATA bit 3 of a frame from requester 1
    req  = 4'b0010;
    data = 32'h0000_9600;
    wait_grant(4'b0010, 2'd1, "mrst", n);
    req = 4'd0;
    for (int i = 0; i < 17; i++) tick();
    chk("mrst_pre", {30'd0, busy, tx}, 32'b10);
    reset_n = 1'b0;
    #1;
    chk("mrst_async", {24'd0, tx, busy, baud, grant, owner[0]}, {24'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
    tick();
    tick();
    chk("mrst_held", {23'd0, tx, busy, baud, grant, owner}, {23'd0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0});
    reset_n = 1'b1;
    req     = 4'b0001;
    data    = 32'h0000_00E7;
    wait_grant(4'b0001, 2'd0, "post", n);
    req = 4'd0;
    frame(8'hE7, "post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
